lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- MEM-stage load/store initiator that drives the word-addressed, single-port data memory. Memory write is synchronous and read is asynchronous.
- Converts byte addresses plus access size into word-indexed memory requests.
- Sub-word stores (byte/half) run as a 2-cycle read-modify-write with a pipeline stall.
- Sub-word loads are extracted from the word and then sign- or zero-extended.

Parameters:
- ADDR_W, 32, byte-address width from the ALU.
- DATA_W, 32, data word width; must be 32.

Ports:
- CLK  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- MemReadM  in  1  load request this cycle
- MemWriteM  in  1  store request this cycle
- SizeM  in  2  00 byte, 01 half, 10 word, 11 treated as word
- UnsignedM  in  1  1 = zero-extend loads, 0 = sign-extend
- ALUOutM  in  32  byte address
- WriteDataM  in  32  store data, right-aligned
- LoadDataM  out  32  extended load result
- StallM  out  1  holds IF/ID/EX/MEM stages when 1
- MisalignM  out  1  misaligned-access flag (feature-dependent)
- DmWE  out  1  data-memory write enable
- DmAddr  out  32  word index = ALUOutM >> 2
- DmWData  out  32  full word to write
- DmRData  in  32  asynchronous read word from memory

Behaviour:
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by ALUOutM[1:0]. Halfword selected by ALUOutM[1].
- FSM has 2 states, IDLE and WRITE. Registers: state, addr_q (word index), merged_q (32 bits). Reset values: state = IDLE, addr_q = 0, merged_q = 0.
- IDLE, word store: DmWE=1, DmAddr=ALUOutM>>2, DmWData=WriteDataM, StallM=0. Stays in IDLE.
- IDLE, sub-word store:
  - Outputs: DmWE=0, StallM=1.
  - Register merged_q = DmRData with the selected lane(s) replaced by WriteDataM[7:0] or WriteDataM[15:0].
  - Register addr_q. Next state = WRITE.
- WRITE: DmWE=1, DmAddr=addr_q, DmWData=merged_q, StallM=0. Next state = IDLE. Inputs are ignored in this cycle; upstream has held them during the stall and advances after this cycle.
- Load (IDLE, MemReadM=1, MemWriteM=0): single cycle, combinational. LoadDataM = extended lane(s) of DmRData. StallM=0, DmWE=0.
- LoadDataM = 0 whenever no load is in progress, including the WRITE state.
- MemReadM and MemWriteM both 1: the store wins and LoadDataM=0.
- Idle outputs: DmWE=0, DmWData=0, StallM=0, DmAddr=ALUOutM>>2.
- Reset during WRITE: returns to IDLE immediately, no write occurs, merged_q cleared.
- Reset output values: StallM=0, DmWE=0, MisalignM=0, LoadDataM=0 (no request active).
- Latency: loads and word stores take 1 cycle. Sub-word stores take 2 cycles, with exactly 1 stall cycle.
- Back-to-back sub-word stores: each takes 2 cycles, and no store is dropped.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Misaligned means: half with ALUOutM[0]=1, or word with ALUOutM[1:0]!=0.
- With the macro:
  - A misaligned access is suppressed: DmWE=0, no FSM transition, LoadDataM=0.
  - MisalignM=1 combinationally in that cycle.
  - A registered sticky copy is held internally and cleared only by rst.
- Without the macro:
  - Low address bits are masked to the access size (half ignores bit 0; word ignores bits 1:0) and the access proceeds.
  - MisalignM is tied to 0.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - FSM state typedef {IDLE, WRITE}
  - the lane-extract and lane-merge functions
- One natural sub-module: lsu_lane_align, purely combinational. It performs the merge for stores and the extract/extend for loads, and is shared by both paths.

Test Plan:
- Word store/load: sw 0xDEADBEEF at byte address 0x10 → DmWE=1, DmAddr=4, 1 cycle, StallM=0. Then lw 0x10 → LoadDataM=0xDEADBEEF.
- Byte store RMW:
  - Setup: memory word 4 = 0x11223344.
  - Stimulus: sb 0xAA at 0x12.
  - Cycle 1: StallM=1, DmWE=0.
  - Cycle 2: DmWE=1, DmWData=0x11AA3344.
- Signed/unsigned loads on word 0x80FF7F01 at 0x20:
  - lb 0x21 → 0x0000007F
  - lb 0x22 → 0xFFFFFFFF
  - lbu 0x23 → 0x00000080
  - lh 0x22 → 0xFFFF80FF
  - lhu 0x22 → 0x000080FF
- Simultaneous MemReadM and MemWriteM (sw 0x5 at 0x8) → write occurs, LoadDataM=0.
- Reset mid-RMW: sh 0xBEEF at 0x12, assert rst in the WRITE cycle before the clock edge → no write, word 4 unchanged, StallM=0, state IDLE.
- Misaligned word access at 0x13:
  - With LSU_MISALIGN_TRAP_EN: MisalignM=1, DmWE=0.
  - Without it: write goes to DmAddr=4, MisalignM=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store initiator: size encodings,
// FSM state type and the byte-lane helpers used by both load and store paths.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } lsu_state_e;

    // Lane offset after masking the low address bits to the access size.
    function automatic logic [1:0] align_off(input logic [1:0] addr_lo, input logic [1:0] size);
        logic [1:0] off;
        case (size)
            SZ_BYTE: off = addr_lo;
            SZ_HALF: off = {addr_lo[1], 1'b0};
            default: off = 2'b00;
        endcase
        return off;
    endfunction

    // Half needs bit 0 clear, word needs bits 1:0 clear (size 11 counts as word).
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

    // Pull the addressed lane(s) out of a little-endian word and extend.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic is_uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = is_uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = is_uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of a word with right-aligned store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [15:0] wdata,
                                               input logic [1:0] off, input logic [1:0] size);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: r[{off, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (off[1]) r[31:16] = wdata;
                else        r[15:0]  = wdata;
            end
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Pipeline-side request signals and data-memory port of the load/store initiator.
interface lsu_mem_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              MemReadM;
    logic              MemWriteM;
    logic [1:0]        SizeM;
    logic              UnsignedM;
    logic [ADDR_W-1:0] ALUOutM;
    logic [DATA_W-1:0] WriteDataM;
    logic [DATA_W-1:0] LoadDataM;
    logic              StallM;
    logic              MisalignM;
    logic              DmWE;
    logic [ADDR_W-1:0] DmAddr;
    logic [DATA_W-1:0] DmWData;
    logic [DATA_W-1:0] DmRData;

    // Initiator view.
    modport master (
        input  MemReadM, MemWriteM, SizeM, UnsignedM, ALUOutM, WriteDataM, DmRData,
        output LoadDataM, StallM, MisalignM, DmWE, DmAddr, DmWData
    );

    // Pipeline plus memory view.
    modport slave (
        output MemReadM, MemWriteM, SizeM, UnsignedM, ALUOutM, WriteDataM, DmRData,
        input  LoadDataM, StallM, MisalignM, DmWE, DmAddr, DmWData
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering shared by loads (extract + extend) and
// sub-word stores (merge into the word read from memory).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [1:0] off;

    // Mask the offset to the access size, then extract and merge from the same lane.
    always_comb begin
        off       = align_off(addr_lo, size);
        load_data = lane_extract(rdata, off, size, is_unsigned);
        merged    = lane_merge(rdata, wdata, off, size);
    end
endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator for a word-addressed single-port data memory.
// Word stores and loads finish in one cycle; byte/half stores run as a
// read-modify-write with one stall cycle.
// Optional: define LSU_MISALIGN_TRAP_EN to suppress misaligned accesses and
// flag them on MisalignM; otherwise low address bits are masked to the size.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accept requests; word store/load complete here, sub-word store
//       | reads the word, merges it and stalls the pipeline
// WRITE | write the merged word to the latched word index
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               CLK,
    input  logic               rst,
    lsu_mem_initiator_if.master bus
);
    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] merged_q, merged_d;

    logic [ADDR_W-1:0] word_idx;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged_word;
    logic              misalign_now;

    assign word_idx = {2'b00, bus.ALUOutM[ADDR_W-1:2]};

    lsu_lane_align u_align (
        .rdata       (bus.DmRData),
        .wdata       (bus.WriteDataM[15:0]),
        .addr_lo     (bus.ALUOutM[1:0]),
        .size        (bus.SizeM),
        .is_unsigned (bus.UnsignedM),
        .load_data   (load_ext),
        .merged      (merged_word)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic sticky_q, sticky_d;

    assign misalign_now = (state_q == IDLE) && (bus.MemReadM || bus.MemWriteM)
                          && is_misaligned(bus.ALUOutM[1:0], bus.SizeM);
    assign sticky_d     = sticky_q | misalign_now;
    assign bus.MisalignM = misalign_now;

    // Sticky record of any suppressed access, cleared only by reset.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) sticky_q <= 1'b0;
        else     sticky_q <= sticky_d;
    end
`else
    assign misalign_now  = 1'b0;
    assign bus.MisalignM = 1'b0;
`endif

    // Next-state and memory/pipeline outputs; the store path wins over a load.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        merged_d      = merged_q;
        bus.DmWE      = 1'b0;
        bus.DmAddr    = word_idx;
        bus.DmWData   = '0;
        bus.StallM    = 1'b0;
        bus.LoadDataM = '0;
        case (state_q)
            IDLE: begin
                if (misalign_now) begin
                    // access suppressed, nothing else to do
                end else if (bus.MemWriteM) begin
                    if (bus.SizeM == SZ_BYTE || bus.SizeM == SZ_HALF) begin
                        bus.StallM = 1'b1;
                        merged_d   = merged_word;
                        addr_d     = word_idx;
                        state_d    = WRITE;
                    end else begin
                        bus.DmWE    = 1'b1;
                        bus.DmWData = bus.WriteDataM;
                    end
                end else if (bus.MemReadM) begin
                    bus.LoadDataM = load_ext;
                end
            end
            WRITE: begin
                bus.DmWE    = 1'b1;
                bus.DmAddr  = addr_q;
                bus.DmWData = merged_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and the latched read-modify-write word/index.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            merged_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            merged_q <= merged_d;
        end
    end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: stimulus pushes per-cycle expected
// outputs and expected memory writes; a monitor pops and compares on negedge.
module tb_lsu_mem_initiator;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_initiator_if bus ();

    lsu_mem_initiator dut (
        .CLK (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:63];
    assign bus.DmRData = mem[bus.DmAddr[5:0]];

    always @(posedge clk) begin
        if (bus.DmWE === 1'b1) mem[bus.DmAddr[5:0]] = bus.DmWData;
    end

    typedef struct {
        string       nm;
        logic [31:0] load;
        logic        stall;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mis;
    } cyc_t;

    typedef struct {
        string       nm;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    cyc_t cyc_q[$];
    wr_t  wr_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push_exp(input string nm, input logic [31:0] e_load, input logic e_stall,
                            input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                            input logic e_mis);
        cyc_t c;
        wr_t  w;
        c.nm = nm; c.load = e_load; c.stall = e_stall; c.we = e_we;
        c.addr = e_addr; c.wdata = e_wdata; c.mis = e_mis;
        cyc_q.push_back(c);
        if (e_we) begin
            w.nm = nm; w.addr = e_addr; w.data = e_wdata;
            wr_q.push_back(w);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.MemReadM   = rd;
        bus.MemWriteM  = wr;
        bus.SizeM      = sz;
        bus.UnsignedM  = uns;
        bus.ALUOutM    = a;
        bus.WriteDataM = wd;
    endtask

    // One pipeline cycle: apply a request just after the edge, record what must come out.
    task automatic step(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] e_load, input logic e_stall, input logic e_we,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic e_mis);
        @(posedge clk);
        #1;
        drive(rd, wr, sz, uns, a, wd);
        push_exp(nm, e_load, e_stall, e_we, e_addr, e_wdata, e_mis);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    endtask

    // Monitor: per-cycle output check plus memory-write scoreboard.
    initial begin
        cyc_t c;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                n_cmp++;
                if (bus.LoadDataM !== c.load || bus.StallM !== c.stall || bus.DmWE !== c.we ||
                    bus.DmAddr !== c.addr || bus.DmWData !== c.wdata || bus.MisalignM !== c.mis) begin
                    n_bad++;
                    $display("FAIL %s: got load=%h stall=%b we=%b addr=%h wdata=%h mis=%b; want load=%h stall=%b we=%b addr=%h wdata=%h mis=%b",
                             c.nm, bus.LoadDataM, bus.StallM, bus.DmWE, bus.DmAddr, bus.DmWData,
                             bus.MisalignM, c.load, c.stall, c.we, c.addr, c.wdata, c.mis);
                end
            end
            if (bus.DmWE === 1'b1) begin
                n_cmp++;
                if (wr_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got addr=%h data=%h; want no write",
                             bus.DmAddr, bus.DmWData);
                end else begin
                    w = wr_q.pop_front();
                    if (bus.DmAddr !== w.addr || bus.DmWData !== w.data) begin
                        n_bad++;
                        $display("FAIL write_%s: got addr=%h data=%h; want addr=%h data=%h",
                                 w.nm, bus.DmAddr, bus.DmWData, w.addr, w.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got simulation still running; want finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        push_exp("reset", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // word store then load back
        step("sw_10",  1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 32'h4, 32'hDEADBEEF, 1'b0);
        step("lw_10",  1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h4, 32'h0,        1'b0);

        // byte store read-modify-write
        idle_cycle();
        mem[4] = 32'h11223344;
        step("sb_12_c1", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h000000AA, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0,        1'b0);
        step("sb_12_c2", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h000000AA, 32'h0, 1'b0, 1'b1, 32'h4, 32'h11AA3344, 1'b0);
        step("lw_after_sb", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h11AA3344, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0);

        // back-to-back byte stores
        step("sb_10_c1", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h00000055, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0,        1'b0);
        step("sb_10_c2", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h00000055, 32'h0, 1'b0, 1'b1, 32'h4, 32'h11AA3355, 1'b0);
        step("sb_13_c1", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h00000066, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0,        1'b0);
        step("sb_13_c2", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h00000066, 32'h0, 1'b0, 1'b1, 32'h4, 32'h66AA3355, 1'b0);
        step("lw_after_b2b", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h66AA3355, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0);

        // signed / unsigned sub-word loads
        idle_cycle();
        mem[8] = 32'h80FF7F01;
        step("lb_21",  1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 32'h0000007F, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
        step("lb_22",  1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h22, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
        step("lbu_23", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0, 32'h00000080, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
        step("lh_22",  1'b1, 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
        step("lhu_22", 1'b1, 1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'h000080FF, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
        step("lh_20",  1'b1, 1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 32'h00007F01, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);

        // read and write together: store wins
        step("rw_sw_08", 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h08, 32'h00000005, 32'h0,        1'b0, 1'b1, 32'h2, 32'h00000005, 1'b0);
        step("lw_08",    1'b1, 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0,        32'h00000005, 1'b0, 1'b0, 32'h2, 32'h0,        1'b0);

        // reset in the WRITE cycle of a halfword store
        step("sh_12_c1", 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000BEEF, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
        push_exp("rst_in_write", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("lw_after_rst", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h66AA3355, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0);

        // misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        step("sw_13_mis", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h13, 32'h12345678, 32'h0, 1'b0, 1'b0, 32'h4, 32'h0, 1'b1);
        step("lw_after_mis", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h66AA3355, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0);
        step("lh_23_mis", 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h23, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1);
`else
        step("sw_13_mask", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h13, 32'h12345678, 32'h0, 1'b0, 1'b1, 32'h4, 32'h12345678, 1'b0);
        step("lw_after_mask", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0);
        step("lh_23_mask", 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h23, 32'h0, 32'hFFFF80FF, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
`endif
        idle_cycle();
        repeat (2) @(negedge clk);

        n_cmp++;
        if (cyc_q.size() != 0 || wr_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got pending cycles=%0d writes=%0d; want 0 and 0",
                     cyc_q.size(), wr_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
